// File: rtl/hdmi_cfg_pkg.sv
// rtl/hdmi_cfg_pkg.sv - shared types and constants for the HDMI transmitter configuration path
package hdmi_cfg_pkg;

  // Byte-level I2C write engine states
  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT,
    ACK,
    STOP,
    DONE
  } i2c_state_e;

  // ADV7513 write address (R/W bit included)
  localparam logic [7:0] ADV7513_ADDR = 8'h72;

  localparam int DEFAULT_CLK_FREQ = 50_000_000;
  localparam int DEFAULT_I2C_FREQ = 100_000;

  // System clock cycles per quarter SCL period
  function automatic int quarter_div(input int clk_freq, input int i2c_freq);
    return clk_freq / (4 * i2c_freq);
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// rtl/i2c_quarter_tick.sv - quarter-SCL-period divider with registered tick output
module i2c_quarter_tick #(
  parameter int QDIV = 125
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int CW = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(QDIV - 1);

  logic [CW-1:0] cnt_q;
  logic          tick_q;

  // Count 0..QDIV-1 while enabled; tick is registered so it is glitch-free and lands one cycle after the wrap
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (clear_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (enable_i) begin
      tick_q <= (cnt_q == LAST);
      cnt_q  <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end else begin
      tick_q <= 1'b0;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/i2c_write_master.sv
// rtl/i2c_write_master.sv - single 3-byte I2C write engine (address, sub-address, data)
module i2c_write_master
  import hdmi_cfg_pkg::*;
#(
  parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
  parameter int I2C_FREQ = DEFAULT_I2C_FREQ
) (
  input  logic        clock_50,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  slave_address,
  input  logic [15:0] register_data,
  input  logic        i2c_serial_data_input,
  output logic        i2c_serial_data_output,
  output logic        i2c_serial_clock,
  output logic        busy,
  output logic        done,
  output logic        ack_error
);

  localparam int QDIV = quarter_div(CLK_FREQ, I2C_FREQ);

  i2c_state_e  state_q, state_d;
  logic [1:0]  qtr_q, qtr_d;
  logic [4:0]  bit_q, bit_d;
  logic [23:0] shift_q, shift_d;
  logic        ack_err_q, ack_err_d;
  logic [4:0]  bit_inc;
  logic        accept;
  logic        tick;
  logic        running;

  // A request is only taken from IDLE; starts during a transfer or in the DONE cycle are dropped
  assign accept  = (state_q == IDLE) && start;
  assign running = (state_q == START) || (state_q == BIT) ||
                   (state_q == ACK)   || (state_q == STOP);

  // Bit counter wraps after the 24th bit so bit_q==0 in ACK marks the final byte
  assign bit_inc = (bit_q == 5'd23) ? 5'd0 : bit_q + 5'd1;

  i2c_quarter_tick #(
    .QDIV(QDIV)
  ) u_quarter_tick (
    .clk_i   (clock_50),
    .rst_i   (reset),
    .clear_i (accept),
    .enable_i(running),
    .tick_o  (tick)
  );

  // State and datapath registers
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      qtr_q     <= 2'd0;
      bit_q     <= 5'd0;
      shift_q   <= 24'd0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      ack_err_q <= ack_err_d;
    end
  end

  // Next-state logic: everything past IDLE/DONE advances only on quarter ticks
  always_comb begin
    state_d   = state_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    ack_err_d = ack_err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = START;
          qtr_d     = 2'd0;
          bit_d     = 5'd0;
          shift_d   = {slave_address, register_data};
          ack_err_d = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          if (qtr_q == 2'd1) begin
            state_d = BIT;
            qtr_d   = 2'd0;
          end else begin
            qtr_d = qtr_q + 2'd1;
          end
        end
      end
      BIT: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd3) begin
            shift_d = {shift_q[22:0], 1'b0};
            bit_d   = bit_inc;
            if (bit_inc[2:0] == 3'd0) begin
              state_d = ACK;
            end
          end
        end
      end
      ACK: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd2 && i2c_serial_data_input) begin
            ack_err_d = 1'b1;
          end
          if (qtr_q == 2'd3) begin
            state_d = (ack_err_q || bit_q == 5'd0) ? STOP : BIT;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (qtr_q == 2'd2) begin
            state_d = DONE;
            qtr_d   = 2'd0;
          end else begin
            qtr_d = qtr_q + 2'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus and status outputs decoded from state and quarter; SDA=1 means released
  always_comb begin
    i2c_serial_clock       = 1'b1;
    i2c_serial_data_output = 1'b1;
    busy                   = running;
    done                   = 1'b0;
    ack_error              = ack_err_q;
    unique case (state_q)
      START: begin
        i2c_serial_clock       = (qtr_q == 2'd0);
        i2c_serial_data_output = 1'b0;
      end
      BIT: begin
        i2c_serial_clock       = (qtr_q == 2'd1) || (qtr_q == 2'd2);
        i2c_serial_data_output = shift_q[23];
      end
      ACK: begin
        i2c_serial_clock       = (qtr_q == 2'd1) || (qtr_q == 2'd2);
        i2c_serial_data_output = 1'b1;
      end
      STOP: begin
        i2c_serial_clock       = (qtr_q != 2'd0);
        i2c_serial_data_output = (qtr_q == 2'd2);
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        i2c_serial_clock       = 1'b1;
        i2c_serial_data_output = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_write_master.sv
// tb/tb_i2c_write_master.sv - directed self-checking bench for i2c_write_master
module tb_i2c_write_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  addr = 8'h72;
  logic [15:0] rdata = 16'h0000;
  logic        sda_in;
  logic        sda_o;
  logic        scl;
  logic        busy;
  logic        done;
  logic        ack_error;
  logic        ack_mode = 1'b1;
  logic        slave_pull;

  int n_checks = 0;
  int n_pass = 0;

  // bus monitor state
  logic        scl_p = 1'b1;
  logic        sda_p = 1'b1;
  int          fall_cnt = 0;
  int          n_start_ev = 0;
  int          n_stop_ev = 0;
  int          phase_bad = 0;
  int          run_len = 0;
  bit          len_valid = 1'b0;
  logic [31:0] cap = 32'd0;
  int          ncap = 0;

  int dc;
  int nd;
  int extra;

  i2c_write_master dut (
    .clock_50              (clk),
    .reset                 (rst),
    .start                 (start),
    .slave_address         (addr),
    .register_data         (rdata),
    .i2c_serial_data_input (sda_in),
    .i2c_serial_data_output(sda_o),
    .i2c_serial_clock      (scl),
    .busy                  (busy),
    .done                  (done),
    .ack_error             (ack_error)
  );

  always #5 clk = ~clk;

  // slave pulls SDA low for the slot after every 8 data bits (falls 9, 18, 27 after START)
  assign slave_pull = ack_mode && (fall_cnt != 0) && (fall_cnt % 9 == 0);
  assign sda_in     = sda_o & ~slave_pull;

  always @(negedge clk) begin
    if (!busy) len_valid = 1'b0;
    if (scl_p && scl && sda_p && !sda_o) begin
      n_start_ev++;
      fall_cnt = 0;
      cap      = 32'd0;
      ncap     = 0;
    end
    if (scl_p && scl && !sda_p && sda_o) n_stop_ev++;
    if (scl !== scl_p) begin
      if (len_valid && run_len != 250) phase_bad++;
      run_len   = 1;
      len_valid = busy;
      if (scl) begin
        cap = {cap[30:0], sda_o};
        ncap++;
      end else begin
        fall_cnt++;
      end
    end else begin
      run_len++;
    end
    scl_p = scl;
    sda_p = sda_o;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic run_xfer(input logic [15:0] word, input bit inject,
                          output int done_cyc, output int n_done);
    int cyc;
    rdata = word;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    check("ack_err_clear_on_accept", 32'(ack_error), 32'd0);
    done_cyc = -1;
    n_done   = 0;
    cyc      = 0;
    while (done_cyc < 0 && cyc < 20000) begin
      if (inject && cyc == 3000) begin
        start = 1'b1;
        rdata = 16'h4110;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_scl", 32'(scl), 32'd1);
    check("rst_sda", 32'(sda_o), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ack_error", 32'(ack_error), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // reset during the second byte
    rdata = 16'h9803;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (50 * 125) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_scl", 32'(scl), 32'd1);
    check("midrst_sda", 32'(sda_o), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // full write, all bytes acknowledged
    n_start_ev = 0;
    n_stop_ev  = 0;
    ack_mode   = 1'b1;
    run_xfer(16'h9803, 1'b0, dc, nd);
    check("full_done_cycle", 32'(dc), 32'd14126);
    check("full_done_count", 32'(nd), 32'd1);
    check("full_ack_error", 32'(ack_error), 32'd0);
    check("full_busy_in_done", 32'(busy), 32'd0);
    check("full_nbits", 32'(ncap), 32'd28);
    check("full_stream", cap, {4'b0, 8'h72, 1'b1, 8'h98, 1'b1, 8'h03, 1'b1, 1'b0});
    check("full_start_ev", 32'(n_start_ev), 32'd1);
    check("full_stop_ev", 32'(n_stop_ev), 32'd1);
    @(posedge clk);
    #1;
    check("full_done_one_cycle", 32'(done), 32'd0);

    // NACK on the address byte
    n_start_ev = 0;
    n_stop_ev  = 0;
    ack_mode   = 1'b0;
    run_xfer(16'h9803, 1'b0, dc, nd);
    check("nack_done_cycle", 32'(dc), 32'd5126);
    check("nack_ack_error", 32'(ack_error), 32'd1);
    check("nack_nbits", 32'(ncap), 32'd10);
    check("nack_stream", cap, {22'b0, 8'h72, 1'b1, 1'b0});
    check("nack_start_ev", 32'(n_start_ev), 32'd1);
    check("nack_stop_ev", 32'(n_stop_ev), 32'd1);

    // back-to-back: start held from the DONE cycle into the following one
    ack_mode   = 1'b1;
    rdata      = 16'haf16;
    start      = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_done_ignored_busy", 32'(busy), 32'd0);
    check("b2b_done_low", 32'(done), 32'd0);
    check("b2b_ack_error_held", 32'(ack_error), 32'd1);
    n_start_ev = 0;
    n_stop_ev  = 0;
    run_xfer(16'haf16, 1'b0, dc, nd);
    check("b2b_done_cycle", 32'(dc), 32'd14126);
    check("b2b_ack_error", 32'(ack_error), 32'd0);
    check("b2b_stream", cap, {4'b0, 8'h72, 1'b1, 8'haf, 1'b1, 8'h16, 1'b1, 1'b0});
    check("b2b_stop_ev", 32'(n_stop_ev), 32'd1);
    @(posedge clk);
    #1;

    // start while busy is ignored
    n_start_ev = 0;
    n_stop_ev  = 0;
    run_xfer(16'h5a3c, 1'b1, dc, nd);
    check("busy_start_done_cycle", 32'(dc), 32'd14126);
    check("busy_start_stream", cap, {4'b0, 8'h72, 1'b1, 8'h5a, 1'b1, 8'h3c, 1'b1, 1'b0});
    check("busy_start_nbits", 32'(ncap), 32'd28);
    check("busy_start_start_ev", 32'(n_start_ev), 32'd1);
    extra = 0;
    repeat (2000) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    check("busy_start_extra_done", 32'(extra), 32'd0);
    check("busy_start_idle", 32'(busy), 32'd0);
    check("busy_start_no_new_start", 32'(n_start_ev), 32'd1);

    check("scl_phase_len", 32'(phase_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_write_master.md
Name: i2c_write_master

Overview:
- Byte-level I2C write engine for the HDMI transmitter configuration path.
- Sits directly downstream of the register-table sequencer. Takes one 8-bit slave address plus a 16-bit {sub-address, data} word per request and performs a single 3-byte I2C write.
- Drives SCL and an open-drain SDA enable. Reports completion and NACK status so the sequencer advances only after each write finishes.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- I2C_FREQ, 100000, SCL frequency in Hz.
- QDIV, CLK_FREQ/(4*I2C_FREQ) (=125), clock cycles per quarter SCL period; derived, not overridden.

Ports:
- clock_50  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request strobe, sampled on rising clock_50.
- slave_address  input  8  address byte, R/W bit included (e.g. 0x72).
- register_data  input  16  [15:8] sub-address, [7:0] data.
- i2c_serial_data_input  input  1  SDA pin value, for ACK sampling.
- i2c_serial_data_output  output  1  1 = release SDA (high-Z), 0 = drive low.
- i2c_serial_clock  output  1  SCL, push-pull.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse at transaction end.
- ack_error  output  1  sticky NACK flag; cleared on next accepted start.

Behaviour:
- Reset (async, immediate): state=IDLE, i2c_serial_clock=1, i2c_serial_data_output=1, busy=0, done=0, ack_error=0, divider=0. A reset mid-transaction abandons the transfer with no STOP generated.
- Start acceptance:
  - start=1 in IDLE latches {slave_address, register_data} into a 24-bit shift register.
  - busy=1 and ack_error=0 from the next cycle.
  - start while busy is ignored; no queueing.
- Quarter tick: the divider counts 0..QDIV-1 and ticks at QDIV-1. The divider runs only while busy and is zeroed on acceptance.
- START state, 2 quarters:
  - Q0: SCL=1, SDA falls to 0.
  - Q1: SCL falls to 0.
- BIT state, 4 quarters per bit, MSB first, 24 data bits:
  - Q0: SCL=0, SDA=shift[23] (1 = release).
  - Q1: SCL=1.
  - Q2: SCL=1, hold.
  - Q3: SCL=0, shift left by 1.
- ACK state, after every 8th bit, 4 quarters:
  - SDA released; SCL timing as BIT.
  - i2c_serial_data_input sampled at the end of Q2.
  - Sample 1 sets ack_error=1 and jumps to STOP after Q3, skipping the remaining bytes.
- STOP state, 3 quarters:
  - Q0: SCL=0, SDA=0.
  - Q1: SCL=1.
  - Q2: SDA released.
- DONE state, 1 cycle: done=1, busy=0, next state IDLE. A start in the DONE cycle is ignored; the earliest accepted start is the cycle after.
- Normal latency:
  - 2 + 27*4 + 3 = 113 quarters.
  - done asserts exactly 113*QDIV+1 cycles after the start-sampling edge (14126 at defaults).
- SDA changes only while SCL=0, except START Q0 and STOP Q2.
- Counters: bit counter 5 bits (0..23), byte-boundary ACK when bit_cnt[2:0] wraps to 0. Quarter counter 2 bits, wraps.

Decomposition:
- Shared package (hdmi_cfg_pkg): state enum {IDLE, START, BIT, ACK, STOP, DONE}, ADV7513 slave address constant 8'h72, default CLK_FREQ and I2C_FREQ.
- One natural sub-module: i2c_quarter_tick (parameterised divider, enable plus tick output). The FSM and shift register remain in i2c_write_master.

Test Plan:
- Reset mid-transfer: assert reset during the second byte -> SCL=1, SDA released, busy=0, done=0 in the same cycle. A following start works normally.
- Full write, all ACK: slave_address=0x72, register_data=0x9803, slave model ACKs -> SDA bit stream 0111_0010, 1001_1000, 0000_0011 sampled at SCL rising edges. done pulses once at cycle 14126. ack_error=0.
- NACK on address byte: model releases SDA at the first ACK -> ack_error=1, STOP generated right after the first ACK slot. done at (2+9*4+3)*125+1 = 5126. No sub-address bits driven.
- Start while busy: second start pulse with 0x4110 mid-transfer -> ignored. Bus carries only the first word. Exactly one done.
- Back-to-back: start asserted the cycle after done with 0xaf16 -> accepted, second transfer correct, ack_error cleared at acceptance.
- Protocol checker over all runs: SDA never toggles while SCL=1 except START/STOP. SCL high and low phases are each 2*QDIV = 250 cycles.
